lsu: RTL
========

# lsu

Multi-cycle load/store unit between the execute stage (ALU address, rs2 data) and data memory. Accepts one byte, half or word access at a time from the core, issues a word-aligned request with a byte-lane write mask over a valid/ready memory port, waits for read data, and returns aligned, sign- or zero-extended load data to the register write-back path. Replaces the single-cycle combinational memory access and makes variable-latency memory possible.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32, 4 byte lanes

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core presents an access
- req_ready  out  1  LSU idle, accepts req this cycle
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_sext  in  1  loads: 1 sign-extend, 0 zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, LSB-aligned
- resp_valid  out  1  one-cycle pulse, access complete
- resp_rdata  out  DATA_W  extended load data; 0 for stores
- resp_err  out  1  misaligned access, valid with resp_valid
- mem_valid  out  1  request to memory
- mem_ready  in  1  memory accepts request
- mem_wen  out  1  write request
- mem_addr  out  ADDR_W  {req_addr[31:2], 2'b00}
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_wmask  out  4  byte-enable, 0 for loads
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read word

## Operation

- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. req_valid=1 registers wen/size/sext/addr/wdata, next REQ. mem_rvalid ignored.
- REQ: mem_valid=1; mem_* held stable until mem_ready. On mem_ready: store -> RESP, load -> WAIT.
- WAIT: on mem_rvalid capture extracted data into resp_rdata, next RESP. mem_rvalid in the REQ handshake cycle is ignored; earliest legal is the following cycle.
- RESP: resp_valid=1 for exactly one cycle, next IDLE. req_ready=0 (no back-to-back acceptance in RESP).
- off = addr[1:0]. Mask base: byte 0001, half 0011, word 1111; mem_wmask = (base << off)[3:0]. mem_wdata = (req_wdata << 8*off)[31:0].
- Load: s = mem_rdata >> 8*off; byte -> s[7:0], half -> s[15:0], word -> s; extend to 32 per sext.
- Misaligned: half with off[0]=1, word with off!=0.
- Reset in any state: IDLE, transaction dropped, late mem_rvalid ignored.

## Timing

- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
- Accept at edge 0; mem_valid from cycle 1. Zero-wait store: resp_valid cycle 2. Zero-wait load (rvalid cycle 2): resp_valid cycle 3.
- Each mem_ready stall cycle and each mem_rvalid delay cycle adds one cycle.
- resp_rdata/resp_err registered, stable through RESP; resp_rdata holds until next load capture.

## Configuration

- LSU_MISALIGN_TRAP_EN defined: misaligned request goes IDLE -> RESP directly, no memory request, resp_err=1, resp_rdata=0.
- Undefined: no check; mask/data truncate per shift rules above; resp_err tied 0.

## Structure

- Package lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), state enum, mask base constants.
- Sub-module lsu_align: combinational store lane shift/mask and load extract/extend; FSM and registers in lsu.

## Test plan

- Store byte addr 0x8000_0003 data 0xAB, mem_ready=1 -> mem_addr 0x8000_0000, wmask 1000, wdata 0xAB00_0000, resp_valid cycle 2.
- Load half sext addr 0x8000_0002, rdata 0x8001_1234 at cycle 2 -> resp_rdata 0xFFFF_8001 at cycle 3; zext -> 0x0000_8001.
- Load word, mem_ready low 3 cycles, rvalid 2 cycles late -> mem_* stable while stalled, resp_valid cycle 8, exactly one pulse.
- Word load at 0x8000_0001 with LSU_MISALIGN_TRAP_EN -> no mem_valid, resp_err=1, resp_rdata 0, resp_valid cycle 1.
- rst asserted in WAIT, rvalid arrives next cycle -> state IDLE, no resp_valid, req_ready=1, all outputs at reset values.
- req_valid held high continuously -> one acceptance per transaction, no request accepted during REQ/WAIT/RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Reserved size encoding behaves as a word access.
  function automatic logic misaligned(input size_t size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and memory-side valid/ready port of the LSU.
// slave: the LSU's view; master: the core/memory environment's view.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_size, req_sext, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_wen, req_size, req_sext, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/mask shift and load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_t             size,
  input  logic              sext,
  input  logic              wen,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] st_data,
  output logic [3:0]        st_mask,
  output logic [DATA_W-1:0] ld_data
);

  logic [3:0]        base;
  logic [DATA_W-1:0] sh;

  // Shift store lanes up by the byte offset; shift load lanes down and extend.
  always_comb begin
    base = MASK_W;
    case (size)
      SZ_B:    base = MASK_B;
      SZ_H:    base = MASK_H;
      default: base = MASK_W;
    endcase
    st_mask = wen ? (base << off) : 4'b0000;
    st_data = wdata << {off, 3'b000};
    sh      = rdata >> {off, 3'b000};
    case (size)
      SZ_B:    ld_data = {{(DATA_W-8){sext & sh[7]}}, sh[7:0]};
      SZ_H:    ld_data = {{(DATA_W-16){sext & sh[15]}}, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: IDLE -> REQ -> (WAIT) -> RESP.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  state_t            state, state_nx;
  logic              wen_q, sext_q;
  size_t             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              accept, mem_valid, req_ready, resp_valid;
  logic [DATA_W-1:0] st_data, ld_data;
  logic [3:0]        st_mask;

  assign accept = (state == IDLE) && bus.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q, req_mis;
  assign req_mis = misaligned(size_t'(bus.req_size), bus.req_addr[1:0]);
`endif

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .size    (size_q),
    .sext    (sext_q),
    .wen     (wen_q),
    .off     (addr_q[1:0]),
    .wdata   (wdata_q),
    .rdata   (bus.mem_rdata),
    .st_data (st_data),
    .st_mask (st_mask),
    .ld_data (ld_data)
  );

  // Next-state and handshake decode.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          state_nx = req_mis ? RESP : REQ;
`else
          state_nx = REQ;
`endif
        end
      end
      REQ: begin
        mem_valid = 1'b1;
        if (bus.mem_ready) state_nx = wen_q ? RESP : WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, request capture and response data/error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wen_q   <= 1'b0;
      size_q  <= SZ_B;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        wen_q   <= bus.req_wen;
        size_q  <= size_t'(bus.req_size);
        sext_q  <= bus.req_sext;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        err_q   <= req_mis;
        if (req_mis) rdata_q <= '0;
`endif
      end
      // Stores report zero data; loads capture only after the handshake cycle.
      if (state == REQ && bus.mem_ready && wen_q) rdata_q <= '0;
      if (state == WAIT && bus.mem_rvalid) rdata_q <= ld_data;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_valid  = mem_valid;
  assign bus.mem_wen    = mem_valid & wen_q;
  assign bus.mem_addr   = mem_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wdata  = mem_valid ? st_data : '0;
  assign bus.mem_wmask  = mem_valid ? st_mask : 4'b0000;

`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.resp_err = err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

endmodule
